gearbox_nm: RTL

Parametrised unit-granular width converter between a PCS upper layer and a lower layer. It accepts IN_UNITS×UNIT_W-bit words and emits OUT_UNITS×UNIT_W-bit words through a BUF_UNITS-deep unit shift buffer. It supports up- and down-conversion, simultaneous push and pop at any fill level, flush, occupancy reporting and overflow detection. Default configuration is 48→64 with a 16-bit unit.

---
 rtl/gearbox_pkg.sv | 30 +++
 rtl/gearbox_unitbuf.sv | 95 +++++++++
 rtl/gearbox_nm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gearbox_pkg.sv
// -----------------------------------------------------------------------------
// gearbox_pkg
//
// Shared definitions for the unit-granular gearbox (gearbox_nm) and its unit
// shift buffer (gearbox_unitbuf).
//
//   UNIT_W_DEF     default number of bits per unit
//   level_width()  number of bits needed to hold a count in 0..max_level
//
// The GEARBOX_CHECK_PARAMS macro expands to a generate-time check. Place it in
// a module body. It rejects buffer depths that cannot hold a partial output
// word plus a whole input word.
// -----------------------------------------------------------------------------
package gearbox_pkg;

  localparam int UNIT_W_DEF = 16;

  // Width of a counter that must represent every value 0..max_level.
  function automatic int level_width(input int max_level);
    return (max_level < 1) ? 1 : $clog2(max_level + 1);
  endfunction

endpackage

`ifndef GEARBOX_CHECK_PARAMS
`define GEARBOX_CHECK_PARAMS(buf_u, in_u, out_u) \
  if (((in_u) < 1) || ((out_u) < 1) || ((buf_u) < (in_u) + (out_u) - 1)) begin : g_bad_params \
    $error("gearbox: illegal units, need IN_UNITS>=1, OUT_UNITS>=1, BUF_UNITS>=IN_UNITS+OUT_UNITS-1"); \
  end
`endif

// File: rtl/gearbox_unitbuf.sv
// -----------------------------------------------------------------------------
// gearbox_unitbuf
//
// A BUF_UNITS-deep array of UNIT_W-bit registers. Unit 0 is the oldest unit.
// The array supports two operations in one cycle. The pop is applied first and
// the insert second.
//   pop  : shift every unit down by OUT_UNITS positions and zero the top.
//   push : write the IN_UNITS units of in_data starting at unit 'offset'.
//          The caller supplies the offset as the level after any pop.
//   clr  : clear the whole array. It overrides pop and push.
// Unused positions stay zero. A pop zero-fills the top, and a push writes
// only units that sit directly above the valid data.
//
// Ports
//   clk, reset  clock and asynchronous active-high reset
//   clr         synchronous clear
//   pop, push   operation strobes, already qualified by the caller
//   offset      first unit written by a push
//   in_data     IN_UNITS units, unit 0 in the LSBs
//   out_data    the lowest OUT_UNITS units, taken from the registers
// -----------------------------------------------------------------------------
module gearbox_unitbuf
  import gearbox_pkg::*;
#(
  parameter int UNIT_W    = UNIT_W_DEF,
  parameter int IN_UNITS  = 3,
  parameter int OUT_UNITS = 4,
  parameter int BUF_UNITS = 9,
  parameter int OFF_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          pop,
  input  logic                          push,
  input  logic [OFF_W-1:0]              offset,
  input  logic [IN_UNITS*UNIT_W-1:0]    in_data,
  output logic [OUT_UNITS*UNIT_W-1:0]   out_data
);

  logic [UNIT_W-1:0] units_q [BUF_UNITS];
  logic [UNIT_W-1:0] units_d [BUF_UNITS];

  always_comb begin
    // NOTE: the whole array gets a default before any conditional update, so
    // every path assigns every element and no latch is inferred.
    units_d = units_q;

    if (pop) begin
      for (int i = 0; i < BUF_UNITS - OUT_UNITS; i++) begin
        units_d[i] = units_q[i + OUT_UNITS];
      end
      for (int i = BUF_UNITS - OUT_UNITS; i < BUF_UNITS; i++) begin
        units_d[i] = '0;
      end
    end

    // The insert compares against constant positions instead of indexing by
    // the offset. This keeps every array index a constant after unrolling.
    if (push) begin
      for (int i = 0; i < BUF_UNITS; i++) begin
        for (int j = 0; j < IN_UNITS; j++) begin
          if (int'(offset) + j == i) begin
            units_d[i] = in_data[j*UNIT_W +: UNIT_W];
          end
        end
      end
    end

    if (clr) begin
      units_d = '{default: '0};
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < OUT_UNITS; k++) begin
      out_data[k*UNIT_W +: UNIT_W] = units_q[k];
    end
  end

  // NOTE: this data array is reset on purpose. The buffer contents are
  // architecturally zero after reset, and a reset in mid-stream must discard
  // everything buffered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      units_q <= '{default: '0};
    end else begin
      // NOTE: sequential state is updated only with non-blocking assignments,
      // so every flop samples its pre-edge value regardless of process order.
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/gearbox_nm.sv
// -----------------------------------------------------------------------------
// gearbox_nm
//
// Unit-granular width converter between a PCS upper layer and a lower layer.
// It accepts IN_UNITS x UNIT_W-bit words and emits OUT_UNITS x UNIT_W-bit
// words through a BUF_UNITS-deep unit shift buffer. The default configuration
// converts 48-bit words to 64-bit words. Each cycle applies a pop first and a
// push second, so both can happen at any fill level.
//
// Ports
//   clk, reset      clock and asynchronous active-high reset
//   in_enable       global advance. When low, all state holds (flush still acts)
//   flush           synchronous clear of buffer, level and overflow flag
//   in_data         upper-layer word. Unit 0 is in the LSBs and is sent first
//   in_datavalid    in_data is present
//   in_ready        the buffer can absorb one input word (registered state only)
//   in_aligned      fill_level is a multiple of IN_UNITS
//   out_data        lowest OUT_UNITS buffer units
//   out_datavalid   out_data is transferred this cycle
//   out_ready       the lower layer accepts a word
//   fill_level      number of units held
//   overflow_err    sticky flag. An input word was dropped while not ready
// -----------------------------------------------------------------------------
module gearbox_nm
  import gearbox_pkg::*;
#(
  parameter int UNIT_W    = UNIT_W_DEF,
  parameter int IN_UNITS  = 3,
  parameter int OUT_UNITS = 4,
  parameter int BUF_UNITS = 9
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_enable,
  input  logic                              flush,
  input  logic [IN_UNITS*UNIT_W-1:0]        in_data,
  input  logic                              in_datavalid,
  output logic                              in_ready,
  output logic                              in_aligned,
  output logic [OUT_UNITS*UNIT_W-1:0]       out_data,
  output logic                              out_datavalid,
  input  logic                              out_ready,
  output logic [level_width(BUF_UNITS)-1:0] fill_level,
  output logic                              overflow_err
);

  `GEARBOX_CHECK_PARAMS(BUF_UNITS, IN_UNITS, OUT_UNITS)

  // Level arithmetic uses enough headroom for BUF_UNITS + OUT_UNITS, so the
  // intermediate sums never wrap.
  localparam int LVL_W  = level_width(BUF_UNITS + OUT_UNITS);
  localparam int FILL_W = level_width(BUF_UNITS);

  localparam logic [LVL_W-1:0] IN_L      = LVL_W'(IN_UNITS);
  localparam logic [LVL_W-1:0] OUT_L     = LVL_W'(OUT_UNITS);
  localparam logic [LVL_W-1:0] BUF_L     = LVL_W'(BUF_UNITS);
  localparam logic [LVL_W-1:0] READY_MAX = LVL_W'(BUF_UNITS - IN_UNITS);

  logic [LVL_W-1:0] fill_level_q;
  logic [LVL_W-1:0] fill_level_d;
  logic             overflow_err_q;
  logic             overflow_err_d;

  logic             pop;
  logic             push;
  logic             drop;
  logic [LVL_W-1:0] post_pop_lvl;

  always_comb begin
    // in_ready depends on the registered level only. It never depends on
    // out_ready, so the upper layer sees no combinational path from the
    // lower layer.
    in_ready   = (fill_level_q <= READY_MAX);
    in_aligned = ((fill_level_q % IN_L) == '0);

    pop  = in_enable && !flush && out_ready && (fill_level_q >= OUT_L);
    push = in_enable && !flush && in_datavalid && in_ready;
    drop = in_enable && !flush && in_datavalid && !in_ready;

    // The push lands directly above whatever survives this cycle's pop.
    post_pop_lvl = pop ? (fill_level_q - OUT_L) : fill_level_q;

    fill_level_d = push ? (post_pop_lvl + IN_L) : post_pop_lvl;
    if (flush) begin
      fill_level_d = '0;
    end

    overflow_err_d = flush ? 1'b0 : (overflow_err_q || drop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_level_q   <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      fill_level_q   <= fill_level_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  gearbox_unitbuf #(
    .UNIT_W    (UNIT_W),
    .IN_UNITS  (IN_UNITS),
    .OUT_UNITS (OUT_UNITS),
    .BUF_UNITS (BUF_UNITS),
    .OFF_W     (LVL_W)
  ) u_unitbuf (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush),
    .pop      (pop),
    .push     (push),
    .offset   (post_pop_lvl),
    .in_data  (in_data),
    .out_data (out_data)
  );

  assign out_datavalid = pop;
  assign fill_level    = fill_level_q[FILL_W-1:0];
  assign overflow_err  = overflow_err_q;

  a_level_bound: assert property (@(posedge clk) disable iff (reset)
    fill_level_q <= BUF_L)
    else $error("gearbox_nm: fill level above buffer depth");

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    pop |-> (fill_level_q >= OUT_L))
    else $error("gearbox_nm: pop with fewer than OUT_UNITS units");

endmodule
